// File: rtl/sim_mem_pkg.sv
// Shared types and constants for the simulation backing-memory responder.
package sim_mem_pkg;

    localparam logic [3:0]  MEM_OP_LOAD  = 4'd4;
    localparam logic [3:0]  MEM_OP_STORE = 4'd7;
    localparam int          LINE_W       = 128;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } mem_state_t;

endpackage

// File: rtl/mem_lat_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying latency jitter.
// Only instantiated when MEM_RAND_LATENCY_EN is defined.
module mem_lat_lfsr
    import sim_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] lat_jitter
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign lat_jitter = lfsr[2:0];

endmodule

// File: rtl/sim_mem_responder.sv
// Latency-accurate line memory model for the core memory port.
// Optional MEM_RAND_LATENCY_EN adds 0..7 cycles of LFSR jitter per request.
//
// state | meaning
// IDLE  | waiting for mem_req_valid; captures request on the edge it is seen
// WAIT  | latency counter running down to terminal count 0
// RESP  | one-cycle response pulse; store committed on the exit edge
// HOLD  | ignore the core's still-asserted old request for one cycle
module sim_mem_responder
    import sim_mem_pkg::*;
#(
    parameter int          LG_LINES  = 12,
    parameter int          LATENCY   = 4,
    parameter logic [31:0] INIT_WORD = 32'h00000013
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req_valid,
    input  logic [63:0]       mem_req_addr,
    input  logic [3:0]        mem_req_opcode,
    input  logic [LINE_W-1:0] mem_req_store_data,
    output logic              mem_rsp_valid,
    output logic [LINE_W-1:0] mem_rsp_load_data,
    output logic              busy,
    output logic              bad_opcode,
    output logic              out_of_range,
    output logic [63:0]       req_count
);

    localparam int                NLINES = 1 << LG_LINES;
    localparam logic [LINE_W-1:0] FILL   = {4{INIT_WORD}};
    localparam logic [8:0]        LAT_M1 = 9'(LATENCY - 1);

    mem_state_t          state;
    logic [8:0]          cnt;
    logic [LG_LINES-1:0] line_q;
    logic [3:0]          op_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [8:0]          lat_load;
    logic [LG_LINES-1:0] req_line;
    logic                addr_high;
    logic                req_illegal;
    logic                unused_addr_bits;

    // Stored XOR FILL so a power-up-zero array reads back as the fill pattern
    // without needing an initialisation pass.
    logic [LINE_W-1:0]   ram [NLINES];

`ifdef MEM_RAND_LATENCY_EN
    logic [2:0] lat_jitter;

    mem_lat_lfsr u_lat_lfsr (
        .clk        (clk),
        .reset      (reset),
        .lat_jitter (lat_jitter)
    );

    assign lat_load = LAT_M1 + {6'd0, lat_jitter};
`else
    assign lat_load = LAT_M1;
`endif

    assign req_line         = mem_req_addr[LG_LINES+3:4];
    assign addr_high        = |mem_req_addr[63:LG_LINES+4];
    assign req_illegal      = (mem_req_opcode != MEM_OP_LOAD) && (mem_req_opcode != MEM_OP_STORE);
    assign unused_addr_bits = ^mem_req_addr[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            line_q            <= '0;
            op_q              <= '0;
            wdata_q           <= '0;
            mem_rsp_valid     <= 1'b0;
            mem_rsp_load_data <= '0;
            busy              <= 1'b0;
            bad_opcode        <= 1'b0;
            out_of_range      <= 1'b0;
            req_count         <= '0;
        end else begin
            mem_rsp_valid     <= 1'b0;
            mem_rsp_load_data <= '0;
            case (state)
                IDLE: begin
                    if (mem_req_valid) begin
                        line_q    <= req_line;
                        op_q      <= mem_req_opcode;
                        wdata_q   <= mem_req_store_data;
                        cnt       <= lat_load;
                        req_count <= req_count + 64'd1;
                        busy      <= 1'b1;
                        state     <= WAIT;
                        if (req_illegal) bad_opcode   <= 1'b1;
                        if (addr_high)   out_of_range <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 9'd1;
                    if (cnt == 9'd0) begin
                        state         <= RESP;
                        mem_rsp_valid <= 1'b1;
                        if (op_q == MEM_OP_LOAD) begin
                            mem_rsp_load_data <= ram[line_q] ^ FILL;
                        end
                    end
                end
                RESP: state <= HOLD;
                HOLD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == RESP && op_q == MEM_OP_STORE) begin
            ram[line_q] <= wdata_q ^ FILL;
        end
    end

endmodule
